// File: rtl/multdiv_seq_ctrl_if.sv
// rtl/multdiv_seq_ctrl_if.sv - issue/operand/result bundle between execute stage and mult/div sequencer
interface multdiv_seq_ctrl_if #(
    parameter int DATA_W = 32
);
    logic              ctrl_MULT;
    logic              ctrl_DIV;
    logic [DATA_W-1:0] data_operandA;
    logic [DATA_W-1:0] data_operandB;
    logic [DATA_W-1:0] data_result;
    logic              data_exception;
    logic              data_resultRDY;

    // Execute stage side: issues operations and consumes results
    modport master (
        output ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
        input  data_result, data_exception, data_resultRDY
    );

    // Sequencer side
    modport slave (
        input  ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
        output data_result, data_exception, data_resultRDY
    );
endinterface

// File: rtl/multdiv_seq_ctrl.sv
// rtl/multdiv_seq_ctrl.sv - sequencer for signed multiply (settle wait) and radix-2 restoring divide
module multdiv_seq_ctrl #(
    parameter int DATA_W    = 32,
    parameter int MULT_LAT  = 2,
    parameter int DIV_ITERS = 32
) (
    input logic                clock,
    input logic                reset,
    multdiv_seq_ctrl_if.slave  bus
);
    localparam int CNT_W = 6;
    localparam logic [CNT_W-1:0] MULT_LAST = CNT_W'(MULT_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV_ITERS - 1);
    localparam logic [DATA_W-1:0] ONE      = DATA_W'(1);

    typedef enum logic [1:0] {IDLE, MULT_WAIT, DIV_ITER, DIV_FIX} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   a_q, a_d, b_q, b_d;
    logic [DATA_W-1:0]   rem_q, rem_d, quo_q, quo_d, dmag_q, dmag_d;
    logic                sign_q, sign_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic                exc_q, exc_d;
    logic                rdy_q, rdy_d;

    // Multiplier fed only from the latched operands; sign-extended so the low
    // 2*DATA_W bits of the product are the exact signed product.
    logic [2*DATA_W-1:0] prod;
    logic                ovf;
    logic [DATA_W-1:0]   a_mag, b_mag;
    logic [2*DATA_W-1:0] rq_sh;
    logic [DATA_W:0]     diff;

    assign prod  = {{DATA_W{a_q[DATA_W-1]}}, a_q} * {{DATA_W{b_q[DATA_W-1]}}, b_q};
    // Product fits in DATA_W bits only when the upper bits are all copies of bit DATA_W-1
    assign ovf   = ~((&prod[2*DATA_W-1:DATA_W-1]) | ~(|prod[2*DATA_W-1:DATA_W-1]));
    // Magnitudes; negating the most negative value wraps to itself, which is the right unsigned magnitude
    assign a_mag = bus.data_operandA[DATA_W-1] ? (~bus.data_operandA + ONE) : bus.data_operandA;
    assign b_mag = bus.data_operandB[DATA_W-1] ? (~bus.data_operandB + ONE) : bus.data_operandB;
    // One restoring step: remainder stays below the divisor, so the shift never loses its MSB
    assign rq_sh = {rem_q, quo_q} << 1;
    assign diff  = {1'b0, rq_sh[2*DATA_W-1:DATA_W]} - {1'b0, dmag_q};

    // Next-state logic: sequencing first, then a new issue overrides everything (abort)
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dmag_d   = dmag_q;
        sign_d   = sign_q;
        result_d = result_q;
        exc_d    = exc_q;
        rdy_d    = 1'b0;

        case (state_q)
            MULT_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == MULT_LAST) begin
                    result_d = prod[DATA_W-1:0];
                    exc_d    = ovf;
                    rdy_d    = 1'b1;
                    state_d  = IDLE;
                end
            end
            DIV_ITER: begin
                cnt_d = cnt_q + 1'b1;
                if (!diff[DATA_W]) begin
                    rem_d = diff[DATA_W-1:0];
                    quo_d = rq_sh[DATA_W-1:0] | ONE;
                end else begin
                    rem_d = rq_sh[2*DATA_W-1:DATA_W];
                    quo_d = rq_sh[DATA_W-1:0];
                end
                if (cnt_q == DIV_LAST) begin
                    state_d = DIV_FIX;
                end
            end
            DIV_FIX: begin
                if (dmag_q == '0) begin
                    result_d = '0;
                    exc_d    = 1'b1;
                end else begin
                    result_d = sign_q ? (~quo_q + ONE) : quo_q;
                    // A positive quotient of magnitude 2^(DATA_W-1) does not fit
                    exc_d    = ~sign_q & quo_q[DATA_W-1];
                end
                rdy_d   = 1'b1;
                state_d = IDLE;
            end
            default: ;
        endcase

        if (bus.ctrl_MULT || bus.ctrl_DIV) begin
            a_d      = bus.data_operandA;
            b_d      = bus.data_operandB;
            cnt_d    = '0;
            result_d = result_q;
            exc_d    = exc_q;
            rdy_d    = 1'b0;
            if (bus.ctrl_MULT) begin
                state_d = MULT_WAIT;
            end else begin
                rem_d   = '0;
                quo_d   = a_mag;
                dmag_d  = b_mag;
                sign_d  = bus.data_operandA[DATA_W-1] ^ bus.data_operandB[DATA_W-1];
                state_d = (bus.data_operandB == '0) ? DIV_FIX : DIV_ITER;
            end
        end
    end

    // State and registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dmag_q   <= '0;
            sign_q   <= 1'b0;
            result_q <= '0;
            exc_q    <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dmag_q   <= dmag_d;
            sign_q   <= sign_d;
            result_q <= result_d;
            exc_q    <= exc_d;
            rdy_q    <= rdy_d;
        end
    end

    assign bus.data_result    = result_q;
    assign bus.data_exception = exc_q;
    assign bus.data_resultRDY = rdy_q;
endmodule

// File: tb/tb_multdiv_seq_ctrl.sv
// tb/tb_multdiv_seq_ctrl.sv - scoreboard bench for multdiv_seq_ctrl with a behavioural reference model
module tb_multdiv_seq_ctrl;
    localparam int MULT_LAT = 2;
    localparam int DIV_LAT  = 33;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    multdiv_seq_ctrl_if bus ();

    multdiv_seq_ctrl dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        int          due;
        logic [31:0] res;
        logic        exc;
    } exp_t;

    exp_t sb[$];
    exp_t got;
    int   edge_n  = 0;
    int   n_pass  = 0;
    int   n_total = 0;

    always @(posedge clock) edge_n <= edge_n + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h required %h (edge %0d)", name, act, req, edge_n);
    endtask

    // Reference: exact 64-bit signed product, overflow when it does not fit an int
    function automatic void model_mult(input logic [31:0] a, input logic [31:0] b,
                                       output logic [31:0] r, output logic x);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        r = p[31:0];
        x = (p != longint'(int'(p)));
    endfunction

    // Reference: C-style truncating division with the two exceptional cases
    function automatic void model_div(input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] r, output logic x);
        int sa, sbv;
        sa  = a;
        sbv = b;
        if (sbv == 0) begin
            r = 32'h0; x = 1'b1;
        end else if (a == 32'h8000_0000 && sbv == -1) begin
            r = 32'h8000_0000; x = 1'b1;
        end else begin
            r = sa / sbv; x = 1'b0;
        end
    endfunction

    // Monitor: every RDY pulse must match the oldest outstanding expectation
    always @(negedge clock) begin
        if (!reset && bus.data_resultRDY === 1'b1) begin
            if (sb.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_rdy: got RDY at edge %0d required none", edge_n);
            end else begin
                got = sb.pop_front();
                check("result", bus.data_result, got.res);
                check("exception", {31'b0, bus.data_exception}, {31'b0, got.exc});
                check("latency_edge", edge_n, got.due);
            end
        end
    end

    // mode 0 = MULT, 1 = DIV, 2 = both strobes (acts as MULT)
    task automatic issue(input int mode, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int   k;
        @(negedge clock);
        bus.ctrl_MULT     = (mode != 1);
        bus.ctrl_DIV      = (mode != 0);
        bus.data_operandA = a;
        bus.data_operandB = b;
        @(posedge clock);
        #1;
        k = edge_n;
        while (sb.size() > 0 && sb[$].due >= k) void'(sb.pop_back());
        if (mode == 1) begin
            model_div(a, b, e.res, e.exc);
            e.due = k + ((b == 32'h0) ? 1 : DIV_LAT);
        end else begin
            model_mult(a, b, e.res, e.exc);
            e.due = k + MULT_LAT;
        end
        sb.push_back(e);
        bus.ctrl_MULT     = 1'b0;
        bus.ctrl_DIV      = 1'b0;
        bus.data_operandA = $urandom;
        bus.data_operandB = $urandom;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 100 && sb.size() > 0; i++) @(negedge clock);
        if (sb.size() > 0) begin
            n_total++;
            $display("FAIL completion_timeout: got %0d pending required 0", sb.size());
            sb.delete();
        end
        repeat (3) @(negedge clock);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($signed($urandom_range(0, 40)) - 20);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got no finish required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.ctrl_MULT     = 1'b0;
        bus.ctrl_DIV      = 1'b0;
        bus.data_operandA = '0;
        bus.data_operandB = '0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("reset_result", bus.data_result, 32'h0);
        check("reset_exception", {31'b0, bus.data_exception}, 32'h0);
        check("reset_rdy", {31'b0, bus.data_resultRDY}, 32'h0);
        reset = 1'b0;
        repeat (50) @(negedge clock);

        issue(0, 32'd7, 32'hFFFF_FFFA);           wait_done();
        issue(0, 32'h0001_0000, 32'h0001_0000);   wait_done();
        issue(0, 32'h8000_0000, 32'd1);           wait_done();
        issue(1, 32'hFFFF_FFF9, 32'd2);           wait_done();
        issue(1, 32'd100, 32'd7);                 wait_done();
        issue(1, 32'd5, 32'd0);                   wait_done();
        issue(1, 32'h8000_0000, 32'hFFFF_FFFF);   wait_done();
        issue(2, 32'd9, 32'd11);                  wait_done();

        // Abort: divide overtaken by a multiply ten edges later
        issue(1, 32'd100, 32'd7);
        repeat (9) @(posedge clock);
        issue(0, 32'd3, 32'd4);
        wait_done();
        repeat (40) @(negedge clock);

        // New issue on the edge right after the previous completion edge
        issue(0, 32'd6, 32'd7);
        repeat (2) @(posedge clock);
        issue(1, 32'hFFFF_FF9C, 32'd3);
        wait_done();

        for (int n = 0; n < 40; n++) begin
            issue($urandom_range(0, 2), pick(), pick());
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(0, 20)) @(posedge clock);
                issue($urandom_range(0, 2), pick(), pick());
            end
            wait_done();
        end

        // Reset during a divide: no completion, outputs cleared
        issue(1, 32'd1000, 32'd3);
        repeat (10) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        sb.delete();
        repeat (2) @(negedge clock);
        check("midreset_result", bus.data_result, 32'h0);
        check("midreset_exception", {31'b0, bus.data_exception}, 32'h0);
        check("midreset_rdy", {31'b0, bus.data_resultRDY}, 32'h0);
        reset = 1'b0;
        repeat (50) @(negedge clock);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/multdiv_seq_ctrl.md
Name: multdiv_seq_ctrl

Overview:
Sequential front end and result stage for the 32-bit signed Wallace multiplier (thirty_two_wallace_multipiler), plus a radix-2 iterative signed divider sharing the same operand registers and result path. It accepts one-cycle ctrl_MULT/ctrl_DIV issue pulses, latches the operands, and holds them stable while the multiplier settles or the divider iterates. It then registers the result and exception and raises a one-cycle data_resultRDY. It sits between the processor's execute stage and the combinational multiplier.

Parameters:
DATA_W, 32, operand/result width; must be 32 to match the multiplier.
MULT_LAT, 2, settle cycles allowed for the combinational multiplier before capture; legal range 1..15.
DIV_ITERS, 32, divider iterations; must equal DATA_W.

Ports:
clock  in  1  single clock, rising edge.
reset  in  1  synchronous, active-high.
ctrl_MULT  in  1  one-cycle issue pulse for multiply.
ctrl_DIV  in  1  one-cycle issue pulse for divide.
data_operandA  in  32  signed dividend/multiplicand; sampled only on an issue edge.
data_operandB  in  32  signed divisor/multiplier; sampled only on an issue edge.
data_result  out  32  registered result.
data_exception  out  1  registered overflow or divide-by-zero flag.
data_resultRDY  out  1  one-cycle completion pulse.

Behaviour:
- Clocking and reset: one clock, synchronous active-high reset.
- Reset: state=IDLE, counter=0, operand regs=0, data_result=0, data_exception=0, data_resultRDY=0. Reset mid-operation aborts the operation and no RDY is produced for it.
- States: IDLE, MULT_WAIT, DIV_ITER, DIV_FIX.
- Issue: the edge that samples ctrl_MULT=1 or ctrl_DIV=1 latches A and B, clears the counter, and enters MULT_WAIT or DIV_ITER. This happens from any state.
- Abort on re-issue: an issue while busy discards the in-flight operation; no RDY is produced for it.
- Both ctrl_MULT and ctrl_DIV high in the same cycle: treated as MULT.
- MULT_WAIT:
  - Multiplier inputs are driven from the latched regs only.
  - The counter increments each edge. When counter==MULT_LAT-1, the edge captures data_result=prod[31:0] and data_exception=ovf, then returns to IDLE.
  - ovf must be 1 exactly when the signed 64-bit product lies outside [-2^31, 2^31-1].
  - data_resultRDY=1 in the cycle after the capture edge. Latency: RDY is high after edge k+MULT_LAT, where k is the issue edge.
- DIV, divide-by-zero: if B==0 at issue, go to DIV_FIX directly. The next edge writes result=0, exception=1. RDY is high after edge k+1.
- DIV, normal path:
  - DIV_ITER works on magnitudes |A| and |B|, with the sign bit stored as A[31]^B[31].
  - Each edge does one restoring step: shift {rem,quo} left by 1, subtract |B|, keep the result if non-negative and set the quotient LSB.
  - After DIV_ITERS edges, go to DIV_FIX. DIV_FIX negates the quotient if the sign bit is set, writes result and exception, and returns to IDLE.
  - Latency: RDY is high after edge k+DIV_ITERS+1 (k+33).
- Division rounding: truncate toward zero. The remainder is discarded.
- Special case A=0x80000000, B=0xFFFFFFFF: result=0x80000000, exception=1.
- Result hold: data_result and data_exception hold their values until the next completion. data_resultRDY is high for exactly one cycle per completed operation.
- Issue coincident with RDY: the RDY for the old operation still pulses, and the new operation starts normally.
- Operand stability: changes on data_operandA/B outside issue edges have no effect.
- Overflow arithmetic: all arithmetic is two's complement. Negating 0x80000000 yields 0x80000000, which is the correct unsigned magnitude for the divider.

Test Plan:
- Reset for 2 cycles with ctrl idle -> data_result=0, data_exception=0, data_resultRDY=0; no RDY while idle for 50 cycles.
- MULT A=7, B=-6 (0xFFFFFFFA) -> data_result=0xFFFFFFD6, exception=0, RDY exactly once, after issue edge +2 (MULT_LAT=2).
- MULT A=0x00010000, B=0x00010000 -> data_result=0x00000000, exception=1; also A=0x80000000, B=1 -> 0x80000000, exception=0.
- DIV A=-7, B=2 -> data_result=0xFFFFFFFD, exception=0, RDY after edge +33; DIV A=100, B=7 -> 14.
- DIV A=5, B=0 -> data_result=0, exception=1, RDY after edge +1. DIV A=0x80000000, B=-1 -> 0x80000000, exception=1.
- Abort: issue DIV 100/7, then MULT 3*4 ten cycles later -> a single RDY at the MULT latency with result=12; no later RDY. Reset asserted during a DIV -> no RDY, outputs reset to 0.
